// File: rtl/kme_clk_gate_pkg.sv
// kme_clk_gate_pkg
// Shared definitions for the KME core clock-gate controller:
//   - gate FSM state encodings and the 2-bit state enum
//   - default wake (settle) and idle (hold-off) cycle counts
package kme_clk_gate_pkg;

  localparam logic [1:0] STATE_OFF_ENC   = 2'd0;
  localparam logic [1:0] STATE_WAKE_ENC  = 2'd1;
  localparam logic [1:0] STATE_ON_ENC    = 2'd2;
  localparam logic [1:0] STATE_DRAIN_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_OFF   = STATE_OFF_ENC,
    ST_WAKE  = STATE_WAKE_ENC,
    ST_ON    = STATE_ON_ENC,
    ST_DRAIN = STATE_DRAIN_ENC
  } gate_state_e;

  localparam int DEFAULT_WAKE_CYCLES = 4;
  localparam int DEFAULT_IDLE_CYCLES = 16;

endpackage

// File: rtl/kme_clk_gate_ack.sv
// kme_clk_gate_ack
// Per-requester 4-phase acknowledge registers. An ack follows its request
// with one cycle of latency, but only while the gated clock is in ON;
// outside ON every ack is held low.
// Ports:
//   clk    in   always-on clock
//   rst_n  in   asynchronous active-low reset
//   in_on  in   gate FSM is in the ON state
//   req    in   per-requester clock request (level)
//   ack    out  per-requester registered grant
module kme_clk_gate_ack #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_on,
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] ack
);

  // ack register array: mirrors req one cycle later while ON, else cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack <= {WIDTH{1'b0}};
    end else if (in_on) begin
      ack <= req;
    end else begin
      ack <= {WIDTH{1'b0}};
    end
  end

endmodule

// File: rtl/kme_clk_gate_ctrl.sv
// kme_clk_gate_ctrl
// Clock-enable sequencer for the KME core clock domain. Wakes the gated
// clock when any requester, busy engine or force_on is active, waits
// WAKE_CYCLES for the gate/PLL to settle, grants acks while ON, and gates
// the clock off after IDLE_CYCLES consecutive idle cycles plus one DRAIN
// cycle. rst_n is expected to be deasserted synchronously upstream.
// Optional feature macro: KME_CLK_GATE_STATS_EN adds wake_cnt / on_cycles.
// Ports:
//   clk        in   free-running always-on clock
//   rst_n      in   asynchronous active-low reset
//   req        in   per-requester clock request (4-phase level)
//   busy       in   per-requester work in flight, holds clock on
//   force_on   in   software override, always-active requester (no ack)
//   ack        out  per-requester grant (registered)
//   clk_en     out  enable to the clock gate cell (registered)
//   gate_state out  current FSM state encoding
//   wake_cnt   out  (stats) saturating OFF->WAKE count
//   on_cycles  out  (stats) wrapping count of clk_en-high cycles
module kme_clk_gate_ctrl
  import kme_clk_gate_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WAKE_CYCLES = DEFAULT_WAKE_CYCLES,
  parameter int IDLE_CYCLES = DEFAULT_IDLE_CYCLES,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] busy,
  input  logic               force_on,
  output logic [NUM_REQ-1:0] ack,
  output logic               clk_en,
  output logic [1:0]         gate_state
`ifdef KME_CLK_GATE_STATS_EN
  ,
  output logic [15:0]        wake_cnt,
  output logic [31:0]        on_cycles
`endif
);

  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  gate_state_e      state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             clk_en_r;
  logic             active_s;

  assign active_s = (|req) | (|busy) | force_on;

  // next-state and shared wake/idle counter
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_OFF: begin
        if (active_s) begin
          state_s = ST_WAKE;
          cnt_s   = WAKE_LOAD;
        end else begin
          cnt_s   = CNT_ZERO;
        end
      end
      ST_WAKE: begin
        // activity is ignored here; ON always re-arms a full idle window
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_ON;
          cnt_s   = IDLE_LOAD;
        end else begin
          cnt_s   = cnt_r - CNT_ONE;
        end
      end
      ST_ON: begin
        // activity wins even on the cycle the idle count expires
        if (active_s) begin
          cnt_s   = IDLE_LOAD;
        end else if (cnt_r == CNT_ZERO) begin
          state_s = ST_DRAIN;
        end else begin
          cnt_s   = cnt_r - CNT_ONE;
        end
      end
      ST_DRAIN: begin
        // clock never stopped, so a late request goes straight back to ON
        if (active_s) begin
          state_s = ST_ON;
          cnt_s   = IDLE_LOAD;
        end else begin
          state_s = ST_OFF;
          cnt_s   = CNT_ZERO;
        end
      end
      default: begin
        state_s = ST_OFF;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // state, counter and registered clock enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_OFF;
      cnt_r    <= CNT_ZERO;
      clk_en_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      clk_en_r <= (state_s != ST_OFF);
    end
  end

  assign clk_en     = clk_en_r;
  assign gate_state = state_r;

  kme_clk_gate_ack #(
    .WIDTH (NUM_REQ)
  ) u_ack (
    .clk   (clk),
    .rst_n (rst_n),
    .in_on (state_r == ST_ON),
    .req   (req),
    .ack   (ack)
  );

`ifdef KME_CLK_GATE_STATS_EN
  logic [15:0] wake_cnt_r;
  logic [31:0] on_cycles_r;

  // wake counter saturates; on-cycle counter wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wake_cnt_r  <= 16'd0;
      on_cycles_r <= 32'd0;
    end else begin
      if ((state_r == ST_OFF) && (state_s == ST_WAKE) && (wake_cnt_r != 16'hFFFF)) begin
        wake_cnt_r <= wake_cnt_r + 16'd1;
      end
      if (clk_en_r) begin
        on_cycles_r <= on_cycles_r + 32'd1;
      end
    end
  end

  assign wake_cnt  = wake_cnt_r;
  assign on_cycles = on_cycles_r;
`endif

endmodule

// File: tb/tb_kme_clk_gate_ctrl.sv
// tb_kme_clk_gate_ctrl
// Randomized + directed stimulus for kme_clk_gate_ctrl. A behavioural model
// (elapsed-wake and consecutive-idle run counters) predicts the registered
// outputs after each clock edge; predictions are queued and a negedge
// monitor pops and compares them against the DUT.
module tb_kme_clk_gate_ctrl;

  localparam int NR = 4;
  localparam int WC = 4;
  localparam int IC = 16;

  localparam int M_OFF   = 0;
  localparam int M_WAKE  = 1;
  localparam int M_ON    = 2;
  localparam int M_DRAIN = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req;
  logic [NR-1:0] busy;
  logic          force_on;
  logic [NR-1:0] ack;
  logic          clk_en;
  logic [1:0]    gate_state;
`ifdef KME_CLK_GATE_STATS_EN
  logic [15:0]   wake_cnt;
  logic [31:0]   on_cycles;
`endif

  kme_clk_gate_ctrl #(
    .NUM_REQ     (NR),
    .WAKE_CYCLES (WC),
    .IDLE_CYCLES (IC),
    .CNT_W       (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .busy       (busy),
    .force_on   (force_on),
    .ack        (ack),
    .clk_en     (clk_en),
    .gate_state (gate_state)
`ifdef KME_CLK_GATE_STATS_EN
    ,
    .wake_cnt   (wake_cnt),
    .on_cycles  (on_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    st;
    logic          ce;
    logic [NR-1:0] ack;
    logic [15:0]   wc;
    logic [31:0]   oc;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // behavioural model state
  int            m_mode;
  int            m_wake_el;
  int            m_idle_run;
  logic [NR-1:0] m_ack;
  int            m_wake_cnt;
  logic [31:0]   m_on;
  exp_t          pend;
  bit            pend_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode     = M_OFF;
    m_wake_el  = 0;
    m_idle_run = 0;
    m_ack      = '0;
    m_wake_cnt = 0;
    m_on       = 32'd0;
  endtask

  // apply inputs for the coming edge and predict the outputs after it
  task automatic drive(input logic [NR-1:0] r, input logic [NR-1:0] b, input logic f);
    bit act;
    req = r;
    busy = b;
    force_on = f;
    act = (r != '0) || (b != '0) || f;
    if (m_mode != M_OFF) m_on = m_on + 32'd1;
    m_ack = (m_mode == M_ON) ? r : '0;
    case (m_mode)
      M_OFF: begin
        if (act) begin
          m_mode = M_WAKE;
          m_wake_el = 0;
          if (m_wake_cnt < 65535) m_wake_cnt++;
        end
      end
      M_WAKE: begin
        m_wake_el++;
        if (m_wake_el == WC) begin
          m_mode = M_ON;
          m_idle_run = 0;
        end
      end
      M_ON: begin
        if (act) m_idle_run = 0;
        else m_idle_run++;
        if (m_idle_run == IC) m_mode = M_DRAIN;
      end
      default: begin
        if (act) begin
          m_mode = M_ON;
          m_idle_run = 0;
        end else begin
          m_mode = M_OFF;
        end
      end
    endcase
    pend.st  = m_mode[1:0];
    pend.ce  = (m_mode != M_OFF);
    pend.ack = m_ack;
    pend.wc  = m_wake_cnt[15:0];
    pend.oc  = m_on;
    pend_valid = 1'b1;
  endtask

  task automatic step(input logic [NR-1:0] r, input logic [NR-1:0] b, input logic f);
    @(posedge clk);
    if (pend_valid) q.push_back(pend);
    #1;
    drive(r, b, f);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_clk_en"}, {31'd0, clk_en}, 32'd0);
    chk({tag, "_ack"}, {28'd0, ack}, 32'd0);
    chk({tag, "_state"}, {30'd0, gate_state}, 32'd0);
  endtask

  // asynchronous reset in the middle of a cycle, then synchronous release
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    pend_valid = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("held_rst");
`ifdef KME_CLK_GATE_STATS_EN
    chk("rst_wake_cnt", {16'd0, wake_cnt}, 32'd0);
    chk("rst_on_cycles", on_cycles, 32'd0);
`endif
    rst_n = 1'b1;
    drive('0, '0, 1'b0);
  endtask

  // scoreboard monitor: compares each edge's prediction away from the edge
  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("gate_state", {30'd0, gate_state}, {30'd0, e.st});
      chk("clk_en", {31'd0, clk_en}, {31'd0, e.ce});
      chk("ack", {28'd0, ack}, {28'd0, e.ack});
`ifdef KME_CLK_GATE_STATS_EN
      chk("wake_cnt", {16'd0, wake_cnt}, {16'd0, e.wc});
      chk("on_cycles", on_cycles, e.oc);
`endif
    end
  end

  initial begin
    rst_n = 1'b0;
    req = '0;
    busy = '0;
    force_on = 1'b0;
    model_reset();
    do_reset();

    // cold wake on req[0], then idle gating
    repeat (8) step('0, '0, 1'b0);
    repeat (20) step(4'b0001, '0, 1'b0);
    repeat (22) step('0, '0, 1'b0);

    // busy holds the clock after req drops; late request lands in DRAIN
    repeat (8)  step(4'b0010, 4'b0010, 1'b0);
    repeat (20) step('0, 4'b0010, 1'b0);
    repeat (IC) step('0, '0, 1'b0);
    repeat (5)  step(4'b0100, '0, 1'b0);

    // multi-requester sharing
    repeat (5)  step(4'b1011, '0, 1'b0);
    repeat (5)  step(4'b0011, '0, 1'b0);
    repeat (22) step('0, '0, 1'b0);

    // three complete wake/idle rounds for the stats counters
    for (int k = 0; k < 3; k++) begin
      repeat (3)  step(4'b1000, '0, 1'b0);
      repeat (IC + 4) step('0, '0, 1'b0);
    end

    // force_on keeps the clock on with no ack, then reset mid-ON
    repeat (40) step('0, '0, 1'b1);
    do_reset();

    // randomized phases
    for (int p = 0; p < 70; p++) begin
      int kind;
      int len;
      logic [NR-1:0] r;
      logic [NR-1:0] b;
      kind = $urandom_range(0, 4);
      len  = $urandom_range(1, 24);
      r = NR'($urandom);
      b = NR'($urandom) & NR'($urandom);
      case (kind)
        0: repeat (len) step('0, '0, 1'b0);
        1: for (int c = 0; c < len; c++) step(NR'($urandom), NR'($urandom) & NR'($urandom), ($urandom_range(0, 9) == 0));
        2: repeat (len) step(r, b, 1'b0);
        3: repeat (len) step('0, '0, ($urandom_range(0, 1) == 1));
        default: begin
          repeat (IC) step('0, '0, 1'b0);
          step(r, '0, 1'b0);
        end
      endcase
    end
    repeat (25) step('0, '0, 1'b0);

    @(posedge clk);
    if (pend_valid) q.push_back(pend);
    pend_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
